// File: rtl/relnet_pkg.sv
// Shared types and constants for the relnet transmit path: FSM states, header sizes,
// lego type codes and the 112-bit UDP header layout handed to host_stack.
package relnet_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StLego,
    StData
  } state_e;

  localparam int unsigned UDP_HDR_BYTES  = 8;
  localparam int unsigned LEGO_HDR_BYTES = 8;

  localparam logic [7:0] LEGO_TYPE_DATA = 8'd0;
  localparam logic [7:0] LEGO_TYPE_ACK  = 8'd1;
  localparam logic [7:0] LEGO_TYPE_CTRL = 8'd2;

  // Largest payload whose UDP length (payload + 16) still fits in 16 bits.
  localparam logic [15:0] MAX_APP_LEN = 16'hFFEF;

  typedef struct packed {
    logic [15:0] length;
    logic [15:0] dest_port;
    logic [15:0] src_port;
    logic [31:0] dest_ip;
    logic [31:0] src_ip;
  } udp_hdr_t;

  function automatic logic [3:0] keep_bytes(input logic [7:0] keep);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, keep[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/relnet_tx_framer.sv
// Transmit framer: UDP header beat, 8-byte lego word (type + 48-bit seqnum), then payload.
// Optional length checking is enabled by defining RELNET_TX_LEN_CHECK_EN.
module relnet_tx_framer
  import relnet_pkg::*;
#(
  parameter logic [31:0] LOCAL_IP   = 32'hC0A80181,
  parameter logic [15:0] LOCAL_PORT = 16'd1000,
  parameter logic [47:0] SEQ_INIT   = 48'd1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  s_meta_dest_ip,
  input  logic [15:0]  s_meta_dest_port,
  input  logic [7:0]   s_meta_type,
  input  logic [15:0]  s_meta_len,
  input  logic         s_meta_valid,
  output logic         s_meta_ready,
  input  logic [63:0]  s_app_axis_tdata,
  input  logic [7:0]   s_app_axis_tkeep,
  input  logic         s_app_axis_tvalid,
  input  logic         s_app_axis_tlast,
  output logic         s_app_axis_tready,
  output logic [111:0] m_udp_hdr_data,
  output logic         m_udp_hdr_valid,
  input  logic         m_udp_hdr_ready,
  output logic [63:0]  m_udp_payload_axis_tdata,
  output logic [7:0]   m_udp_payload_axis_tkeep,
  output logic         m_udp_payload_axis_tvalid,
  output logic         m_udp_payload_axis_tlast,
  output logic         m_udp_payload_axis_tuser,
  input  logic         m_udp_payload_axis_tready,
  output logic         err_len
);

  state_e      state_q, state_d;
  logic [31:0] dest_ip_q;
  logic [15:0] dest_port_q;
  logic [15:0] len_q;
  logic [7:0]  type_q;
  logic [47:0] seq_q, seq_d;
  logic        meta_load;
  logic        meta_drop;
  logic        len_bad;
  logic        data_hs;
  udp_hdr_t    hdr;
  logic [63:0] lego_word;

  assign data_hs = (state_q == StData) && s_app_axis_tvalid && m_udp_payload_axis_tready;

`ifdef RELNET_TX_LEN_CHECK_EN
  logic [16:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [16:0] cnt_next;

  assign cnt_next  = cnt_q + {13'd0, keep_bytes(s_app_axis_tkeep)};
  assign len_bad   = cnt_next != {1'b0, len_q};
  assign meta_drop = s_meta_len > MAX_APP_LEN;
  assign err_len   = err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (meta_load) begin
      cnt_d = '0;
    end else if (data_hs) begin
      cnt_d = cnt_next;
    end
    if (data_hs && s_app_axis_tlast) begin
      err_d = len_bad;
    end
    // Oversized meta is swallowed in IDLE and only reported.
    if ((state_q == StIdle) && s_meta_valid && meta_drop) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign len_bad   = 1'b0;
  assign meta_drop = 1'b0;
  assign err_len   = 1'b0;
`endif

  assign hdr = '{
    length:    len_q + 16'(UDP_HDR_BYTES + LEGO_HDR_BYTES),
    dest_port: dest_port_q,
    src_port:  LOCAL_PORT,
    dest_ip:   dest_ip_q,
    src_ip:    LOCAL_IP
  };
  assign m_udp_hdr_data = hdr;

  // Lane 0 carries the type; lanes 1..6 the seqnum MSB first; lane 7 is zero.
  assign lego_word = {8'h00, seq_q[7:0], seq_q[15:8], seq_q[23:16],
                      seq_q[31:24], seq_q[39:32], seq_q[47:40], type_q};

  always_comb begin
    state_d                   = state_q;
    seq_d                     = seq_q;
    meta_load                 = 1'b0;
    s_meta_ready              = 1'b0;
    m_udp_hdr_valid           = 1'b0;
    s_app_axis_tready         = 1'b0;
    m_udp_payload_axis_tdata  = lego_word;
    m_udp_payload_axis_tkeep  = 8'hFF;
    m_udp_payload_axis_tvalid = 1'b0;
    m_udp_payload_axis_tlast  = (len_q == 16'd0);
    m_udp_payload_axis_tuser  = 1'b0;
    unique case (state_q)
      StIdle: begin
        s_meta_ready = 1'b1;
        if (s_meta_valid && !meta_drop) begin
          meta_load = 1'b1;
          state_d   = StHdr;
        end
      end
      StHdr: begin
        m_udp_hdr_valid = 1'b1;
        if (m_udp_hdr_ready) begin
          state_d = StLego;
        end
      end
      StLego: begin
        m_udp_payload_axis_tvalid = 1'b1;
        if (m_udp_payload_axis_tready) begin
          // Seqnum zero is reserved, so the all-ones value wraps to SEQ_INIT.
          seq_d   = (seq_q == '1) ? SEQ_INIT : seq_q + 48'd1;
          state_d = (len_q == 16'd0) ? StIdle : StData;
        end
      end
      StData: begin
        m_udp_payload_axis_tdata  = s_app_axis_tdata;
        m_udp_payload_axis_tkeep  = s_app_axis_tkeep;
        m_udp_payload_axis_tvalid = s_app_axis_tvalid;
        m_udp_payload_axis_tlast  = s_app_axis_tlast;
        m_udp_payload_axis_tuser  = s_app_axis_tlast && len_bad;
        s_app_axis_tready         = m_udp_payload_axis_tready;
        if (data_hs && s_app_axis_tlast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      seq_q   <= SEQ_INIT;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest_ip_q   <= '0;
      dest_port_q <= '0;
      type_q      <= '0;
      len_q       <= '0;
    end else if (meta_load) begin
      dest_ip_q   <= s_meta_dest_ip;
      dest_port_q <= s_meta_dest_port;
      type_q      <= s_meta_type;
      len_q       <= s_meta_len;
    end
  end

endmodule

// File: tb/tb_relnet_tx_framer.sv
// Self-checking bench for relnet_tx_framer: directed and random messages checked against
// a message-level model (expected header, lego word and beat list per message).
module tb_relnet_tx_framer;
  import relnet_pkg::*;

  localparam logic [31:0] LIP      = 32'hC0A80181;
  localparam logic [15:0] LPORT    = 16'd1000;
  localparam logic [47:0] SEQ_INIT = 48'd1;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  s_meta_dest_ip;
  logic [15:0]  s_meta_dest_port;
  logic [7:0]   s_meta_type;
  logic [15:0]  s_meta_len;
  logic         s_meta_valid;
  logic         s_meta_ready;
  logic [63:0]  s_app_axis_tdata;
  logic [7:0]   s_app_axis_tkeep;
  logic         s_app_axis_tvalid;
  logic         s_app_axis_tlast;
  logic         s_app_axis_tready;
  logic [111:0] m_udp_hdr_data;
  logic         m_udp_hdr_valid;
  logic         m_udp_hdr_ready;
  logic [63:0]  m_udp_payload_axis_tdata;
  logic [7:0]   m_udp_payload_axis_tkeep;
  logic         m_udp_payload_axis_tvalid;
  logic         m_udp_payload_axis_tlast;
  logic         m_udp_payload_axis_tuser;
  logic         m_udp_payload_axis_tready;
  logic         err_len;

  relnet_tx_framer #(
    .LOCAL_IP  (LIP),
    .LOCAL_PORT(LPORT),
    .SEQ_INIT  (SEQ_INIT)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .s_meta_dest_ip           (s_meta_dest_ip),
    .s_meta_dest_port         (s_meta_dest_port),
    .s_meta_type              (s_meta_type),
    .s_meta_len               (s_meta_len),
    .s_meta_valid             (s_meta_valid),
    .s_meta_ready             (s_meta_ready),
    .s_app_axis_tdata         (s_app_axis_tdata),
    .s_app_axis_tkeep         (s_app_axis_tkeep),
    .s_app_axis_tvalid        (s_app_axis_tvalid),
    .s_app_axis_tlast         (s_app_axis_tlast),
    .s_app_axis_tready        (s_app_axis_tready),
    .m_udp_hdr_data           (m_udp_hdr_data),
    .m_udp_hdr_valid          (m_udp_hdr_valid),
    .m_udp_hdr_ready          (m_udp_hdr_ready),
    .m_udp_payload_axis_tdata (m_udp_payload_axis_tdata),
    .m_udp_payload_axis_tkeep (m_udp_payload_axis_tkeep),
    .m_udp_payload_axis_tvalid(m_udp_payload_axis_tvalid),
    .m_udp_payload_axis_tlast (m_udp_payload_axis_tlast),
    .m_udp_payload_axis_tuser (m_udp_payload_axis_tuser),
    .m_udp_payload_axis_tready(m_udp_payload_axis_tready),
    .err_len                  (err_len)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [47:0] m_seq;
  logic        err_pending;
  logic [63:0] app_d[$];
  logic [7:0]  app_k[$];

`ifdef RELNET_TX_LEN_CHECK_EN
  localparam bit LenCheck = 1'b1;
`else
  localparam bit LenCheck = 1'b0;
`endif

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] lego_ref(input logic [7:0] t, input logic [47:0] s);
    logic [7:0]  lanes[8];
    logic [63:0] w;
    lanes[0] = t;
    for (int i = 1; i <= 6; i++) lanes[i] = 8'(s >> (8 * (6 - i)));
    lanes[7] = 8'h00;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = lanes[i];
    return w;
  endfunction

  task automatic gen_app(input int nbytes, input logic [63:0] fixed, input bit use_fixed);
    app_d.delete();
    app_k.delete();
    for (int b = 0; b < (nbytes + 7) / 8; b++) begin
      int rem;
      rem = nbytes - 8 * b;
      app_d.push_back(use_fixed ? fixed : {$urandom, $urandom});
      app_k.push_back(rem >= 8 ? 8'hFF : 8'((1 << rem) - 1));
    end
  endtask

  // mode 0: random backpressure/gaps; mode 1: tready toggles every cycle, app always valid.
  task automatic run_msg(input logic [31:0] ip, input logic [15:0] port, input logic [7:0] typ,
                         input logic [15:0] len, input int mode, input int abort_at);
    logic [63:0]  ed[$];
    logic [7:0]   ek[$];
    logic         el[$];
    logic         eu[$];
    logic [111:0] eh;
    int           oi, ai, tmo, sum;
    bit           tr, stall, app_new;
    sum = 0;
    foreach (app_k[i]) for (int b = 0; b < 8; b++) sum += int'(app_k[i][b]);
    eh = {16'(len + 16), port, LPORT, ip, LIP};
    ed.push_back(lego_ref(typ, m_seq));
    ek.push_back(8'hFF);
    el.push_back(len == 16'd0);
    eu.push_back(1'b0);
    m_seq = (m_seq == 48'hFFFF_FFFF_FFFF) ? SEQ_INIT : m_seq + 48'd1;
    foreach (app_d[i]) begin
      ed.push_back(app_d[i]);
      ek.push_back(app_k[i]);
      el.push_back(i == app_d.size() - 1);
      eu.push_back(LenCheck && (i == app_d.size() - 1) && (sum != int'(len)));
    end

    @(negedge clk);
    s_app_axis_tvalid         = 1'b0;
    m_udp_payload_axis_tready = 1'b0;
    s_meta_dest_ip            = ip;
    s_meta_dest_port          = port;
    s_meta_type               = typ;
    s_meta_len                = len;
    s_meta_valid              = 1'b1;
    #1;
    chk("meta_ready", s_meta_ready, 1'b1);
    chk("idle_tvalid", m_udp_payload_axis_tvalid, 1'b0);
    chk("err_len", err_len, err_pending);
    err_pending = 1'b0;

    @(negedge clk);
    s_meta_valid    = 1'b0;
    m_udp_hdr_ready = (mode != 1);
    #1;
    chk("hdr_valid", m_udp_hdr_valid, 1'b1);
    chk("hdr_data", m_udp_hdr_data, eh);
    chk("meta_ready_hdr", s_meta_ready, 1'b0);
    if (mode == 1) begin
      @(negedge clk);
      m_udp_hdr_ready = 1'b1;
      #1;
      chk("hdr_hold_valid", m_udp_hdr_valid, 1'b1);
      chk("hdr_hold_data", m_udp_hdr_data, eh);
    end

    oi = 0; ai = 0; tmo = 0; tr = 1'b1; stall = 1'b0; app_new = 1'b1;
    while (oi < ed.size() && tmo < 300) begin
      @(negedge clk);
      tmo++;
      m_udp_hdr_ready = 1'b0;
      tr = !tr;
      m_udp_payload_axis_tready = (mode == 1) ? tr : ($urandom_range(0, 4) != 0);
      if (ai < app_d.size()) begin
        if (app_new) s_app_axis_tvalid = (mode == 1) || ($urandom_range(0, 3) != 0);
        s_app_axis_tdata = app_d[ai];
        s_app_axis_tkeep = app_k[ai];
        s_app_axis_tlast = (ai == app_d.size() - 1);
      end else begin
        s_app_axis_tvalid = 1'b0;
      end
      #1;
      chk("meta_ready_busy", s_meta_ready, 1'b0);
      chk("app_tready", s_app_axis_tready, (oi > 0) && m_udp_payload_axis_tready);
      chk("tvalid", m_udp_payload_axis_tvalid, (oi == 0) ? 1'b1 : s_app_axis_tvalid);
      if (stall) chk("hold_valid", m_udp_payload_axis_tvalid, 1'b1);
      if (m_udp_payload_axis_tvalid === 1'b1) begin
        chk("tdata", m_udp_payload_axis_tdata, ed[oi]);
        chk("tkeep", m_udp_payload_axis_tkeep, ek[oi]);
        chk("tlast", m_udp_payload_axis_tlast, el[oi]);
        chk("tuser", m_udp_payload_axis_tuser, eu[oi]);
      end
      stall   = (m_udp_payload_axis_tvalid === 1'b1) && !m_udp_payload_axis_tready;
      app_new = !s_app_axis_tvalid || (s_app_axis_tready === 1'b1);
      if (m_udp_payload_axis_tvalid === 1'b1 && m_udp_payload_axis_tready) begin
        if (oi > 0) ai++;
        oi++;
      end
      if (abort_at >= 0 && oi == abort_at) begin
        @(negedge clk);
        rst = 1'b1;
        s_app_axis_tvalid = 1'b0;
        #1;
        chk("abort_tvalid", m_udp_payload_axis_tvalid, 1'b0);
        chk("abort_hdr_valid", m_udp_hdr_valid, 1'b0);
        chk("abort_app_tready", s_app_axis_tready, 1'b0);
        chk("abort_err_len", err_len, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        m_seq = SEQ_INIT;
        err_pending = 1'b0;
        return;
      end
    end
    chk("payload_done", oi, ed.size());
    err_pending = LenCheck && (app_d.size() > 0) && (sum != int'(len));
  endtask

  initial begin
    rst = 1'b1;
    s_meta_dest_ip = '0; s_meta_dest_port = '0; s_meta_type = '0; s_meta_len = '0;
    s_meta_valid = 1'b0;
    s_app_axis_tdata = '0; s_app_axis_tkeep = '0; s_app_axis_tvalid = 1'b0;
    s_app_axis_tlast = 1'b0;
    m_udp_hdr_ready = 1'b0; m_udp_payload_axis_tready = 1'b0;
    m_seq = SEQ_INIT;
    err_pending = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hdr_valid", m_udp_hdr_valid, 1'b0);
    chk("rst_tvalid", m_udp_payload_axis_tvalid, 1'b0);
    chk("rst_app_tready", s_app_axis_tready, 1'b0);
    chk("rst_err_len", err_len, 1'b0);
    chk("rst_meta_ready", s_meta_ready, 1'b1);
    rst = 1'b0;

    // Reference message: hdr {24,1234,1000,C0A80180,C0A80181}, lego seq 1, one 0f.. beat.
    gen_app(8, 64'h0f0f_0f0f_0f0f_0f0f, 1'b1);
    run_msg(32'hC0A80180, 16'd1234, LEGO_TYPE_DATA, 16'd8, 0, -1);

    for (int i = 0; i < 3; i++) begin
      gen_app(16, '0, 1'b0);
      run_msg(32'hC0A80180, 16'd1234, LEGO_TYPE_DATA, 16'd16, 0, -1);
    end

    gen_app(0, '0, 1'b0);
    run_msg(32'h0A000001, 16'd77, LEGO_TYPE_ACK, 16'd0, 0, -1);
    gen_app(13, '0, 1'b0);
    run_msg(32'h0A000002, 16'd78, LEGO_TYPE_CTRL, 16'd13, 0, -1);

    gen_app(24, '0, 1'b0);
    run_msg(32'h0A000003, 16'd79, LEGO_TYPE_DATA, 16'd24, 1, -1);
    gen_app(0, '0, 1'b0);
    run_msg(32'h0A000004, 16'd80, LEGO_TYPE_DATA, 16'd0, 1, -1);

`ifdef RELNET_TX_LEN_CHECK_EN
    gen_app(24, '0, 1'b0);
    run_msg(32'h0A000005, 16'd81, LEGO_TYPE_DATA, 16'd16, 0, -1);
    gen_app(8, '0, 1'b0);
    run_msg(32'h0A000006, 16'd82, LEGO_TYPE_DATA, 16'd8, 0, -1);
    @(negedge clk);
    s_meta_len   = 16'hFFF0;
    s_meta_valid = 1'b1;
    #1;
    chk("ovr_meta_ready", s_meta_ready, 1'b1);
    @(negedge clk);
    s_meta_valid = 1'b0;
    #1;
    chk("ovr_hdr_valid", m_udp_hdr_valid, 1'b0);
    chk("ovr_err_len", err_len, 1'b1);
    chk("ovr_meta_ready_after", s_meta_ready, 1'b1);
    gen_app(8, '0, 1'b0);
    run_msg(32'h0A000007, 16'd83, LEGO_TYPE_DATA, 16'd8, 0, -1);
`endif

    for (int i = 0; i < 8; i++) begin
      logic [15:0] len;
      len = 16'($urandom_range(0, 40));
      gen_app(int'(len), '0, 1'b0);
      run_msg($urandom, 16'($urandom), 8'($urandom_range(0, 3)), len,
              int'($urandom_range(0, 1)), -1);
    end

    // Preset the counter to its last value to exercise the wrap to SEQ_INIT.
    @(negedge clk);
    force dut.seq_d = 48'hFFFF_FFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.seq_d;
    m_seq = 48'hFFFF_FFFF_FFFF;
    gen_app(8, '0, 1'b0);
    run_msg(32'h0A000010, 16'd90, LEGO_TYPE_DATA, 16'd8, 0, -1);
    gen_app(8, '0, 1'b0);
    run_msg(32'h0A000011, 16'd91, LEGO_TYPE_DATA, 16'd8, 0, -1);

    gen_app(32, '0, 1'b0);
    run_msg(32'h0A000012, 16'd92, LEGO_TYPE_DATA, 16'd32, 0, 2);
    gen_app(16, '0, 1'b0);
    run_msg(32'h0A000013, 16'd93, LEGO_TYPE_DATA, 16'd16, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
